// File: rtl/imem_loader.sv
// imem_loader: framed byte stream (len, words MSB-first, xor checksum) -> instruction memory writes; holds cpu_rst until a frame checks out
module imem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int RST_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  im_we,
  output logic [ADDR_WIDTH-1:0] im_addr,
  output logic [31:0]           im_wdata,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);
  localparam int CW = $clog2(RST_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD - 1);
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, WORD, CHK, HOLD, DONE, ERR} state_t;
  state_t state, state_n;
  logic [7:0] len_hi, xsum;
  logic [15:0] n, n_in;
  logic [1:0] idx;
  logic [23:0] sh;
  logic [CW-1:0] cnt;
  logic [ADDR_WIDTH:0] wl_next;
  logic acc, len_bad, last;
  assign rx_ready = state inside {LEN_HI, LEN_LO, WORD, CHK};
  assign busy = rx_ready || state == HOLD;
  assign cpu_rst = state != DONE;
  assign done = state == DONE;
  assign error = state == ERR;
  assign acc = rx_valid && rx_ready;
  assign n_in = {len_hi, rx_data};
  assign len_bad = n_in == 16'd0 || 17'(n_in) > (17'd1 << ADDR_WIDTH);
  assign wl_next = words_loaded + 1'b1;
  assign last = 17'(wl_next) == 17'(n);
  always_comb begin
    state_n = state;
    case (state)
      LEN_HI: state_n = acc ? LEN_LO : state;
      LEN_LO: state_n = acc ? (len_bad ? ERR : WORD) : state;
      WORD:   state_n = acc && idx == 2'd3 && last ? CHK : state;
      CHK:    state_n = acc ? (rx_data == xsum ? HOLD : ERR) : state;
      HOLD:   state_n = cnt == HOLD_LAST ? DONE : state;
      default: state_n = start ? LEN_HI : state;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      len_hi <= '0;
      n <= '0;
      xsum <= '0;
      idx <= '0;
      sh <= '0;
      cnt <= '0;
      words_loaded <= '0;
      im_we <= 1'b0;
      im_addr <= '0;
      im_wdata <= '0;
    end else begin
      state <= state_n;
      im_we <= 1'b0;
      cnt <= state == HOLD ? cnt + 1'b1 : '0;
      if (start && !busy) begin
        xsum <= '0;
        words_loaded <= '0;
        idx <= '0;
      end
      if (acc) xsum <= xsum ^ rx_data;
      if (acc && state == LEN_HI) len_hi <= rx_data;
      if (acc && state == LEN_LO) begin
        n <= n_in;
        idx <= '0;
      end
      if (acc && state == WORD) begin
        sh <= {sh[15:0], rx_data};
        idx <= idx + 2'd1;
        if (idx == 2'd3) begin
          im_we <= 1'b1;
          im_addr <= words_loaded[ADDR_WIDTH-1:0];
          im_wdata <= {sh, rx_data};
          words_loaded <= wl_next;
        end
      end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed scoreboard bench for imem_loader
module tb_imem_loader;
  logic clk = 0, rst = 1, start = 0, rx_valid = 0;
  logic [7:0] rx_data = 0;
  logic rx_ready, im_we, cpu_rst, busy, done, error;
  logic [9:0] im_addr;
  logic [31:0] im_wdata;
  logic [10:0] words_loaded;
  int checks = 0, errors = 0;
  logic [41:0] q[$];
  logic [41:0] e;
  logic [7:0] good[15] = '{8'h00, 8'h03, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09,
                           8'h00, 8'h0C, 8'h01, 8'h09, 8'h50, 8'h20, 8'h73};
  imem_loader dut (.clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .cpu_rst(cpu_rst),
    .busy(busy), .done(done), .error(error), .words_loaded(words_loaded));
  always #5 clk = ~clk;
  always @(negedge clk)
    if (im_we) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $error("FAIL write_unexpected observed addr=%0h data=%0h expected none", im_addr, im_wdata);
      end else begin
        e = q.pop_front();
        assert ({im_addr, im_wdata} === e) else begin
          errors++;
          $error("FAIL write observed=%0h expected=%0h", {im_addr, im_wdata}, e);
        end
      end
    end
  task chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task send(input logic [7:0] b, input int gap);
    repeat (gap) begin
      rx_valid = 0;
      rx_data = 8'($urandom);
      @(posedge clk);
      #1;
    end
    rx_valid = 1;
    rx_data = b;
    @(posedge clk);
    #1;
    rx_valid = 0;
    rx_data = 8'($urandom);
  endtask
  task pulse_start();
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
  endtask
  task push_good();
    q.push_back({10'd0, 32'h20080005});
    q.push_back({10'd1, 32'h2009000C});
    q.push_back({10'd2, 32'h01095020});
  endtask
  task frame(input logic [7:0] trailer, input bit gaps);
    for (int i = 0; i < 14; i++) send(good[i], gaps ? int'($urandom_range(0, 3)) : 0);
    send(trailer, gaps ? int'($urandom_range(0, 3)) : 0);
  endtask
  task finish_ok(input string tag);
    chk({tag, "_rst_e"}, cpu_rst, 1);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk({tag, "_rst_hold"}, cpu_rst, 1);
    end
    @(posedge clk);
    #1;
    chk({tag, "_rst_rel"}, cpu_rst, 0);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_words"}, words_loaded, 3);
    chk({tag, "_q_empty"}, q.size(), 0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_outs", {rx_ready, im_we, busy, done, error}, 0);
    chk("rst_vals", {im_addr, im_wdata, words_loaded}, 0);
    rst = 0;
    @(posedge clk);
    #1;
    pulse_start();
    chk("start_ready", rx_ready, 1);
    chk("start_busy", busy, 1);
    push_good();
    frame(8'h73, 0);
    finish_ok("good");
    send(8'hAA, 0);
    chk("idle_byte_words", words_loaded, 3);
    chk("idle_byte_done", done, 1);
    pulse_start();
    chk("reload_cpu_rst", cpu_rst, 1);
    chk("reload_done", done, 0);
    chk("reload_busy", busy, 1);
    chk("reload_words", words_loaded, 0);
    push_good();
    for (int i = 0; i < 6; i++) send(good[i], 0);
    pulse_start();
    for (int i = 6; i < 15; i++) send(good[i], 0);
    finish_ok("reload");
    pulse_start();
    push_good();
    frame(8'h72, 0);
    chk("bad_error", error, 1);
    chk("bad_done", done, 0);
    chk("bad_cpu_rst", cpu_rst, 1);
    chk("bad_ready", rx_ready, 0);
    chk("bad_words", words_loaded, 3);
    chk("bad_q_empty", q.size(), 0);
    pulse_start();
    send(8'h00, 0);
    send(8'h00, 0);
    chk("len0_error", error, 1);
    chk("len0_words", words_loaded, 0);
    pulse_start();
    send(8'h04, 0);
    send(8'h01, 0);
    chk("len1025_error", error, 1);
    chk("len1025_ready", rx_ready, 0);
    chk("len1025_words", words_loaded, 0);
    pulse_start();
    push_good();
    frame(8'h73, 1);
    finish_ok("gap");
    pulse_start();
    push_good();
    for (int i = 0; i < 6; i++) send(good[i], 0);
    chk("mid_we_before", im_we, 1);
    #1 rst = 1;
    #1;
    chk("mid_cpu_rst", cpu_rst, 1);
    chk("mid_outs", {rx_ready, im_we, busy, done, error}, 0);
    chk("mid_words", words_loaded, 0);
    q.delete();
    @(posedge clk);
    #1 rst = 0;
    @(posedge clk);
    #1;
    pulse_start();
    push_good();
    frame(8'h73, 0);
    finish_ok("after_rst");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
